// File: rtl/mc_sequencer_pkg.sv
//------------------------------------------------------------------------------
// mc_sequencer_pkg: state, fault and RV32I opcode encodings | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mc_sequencer_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_IMEM_TO = 2'b10;
  localparam logic [1:0] FLT_DMEM_TO = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [1:0] WDSEL_LOAD = 2'b11;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_NOP: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
//------------------------------------------------------------------------------
// mc_wait_timer: memory-wait counter with clear, enable and terminal count | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mc_wait_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/mc_sequencer.sv
//------------------------------------------------------------------------------
// mc_sequencer: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB) | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [6:0]       Op,
  input  logic             dec_regwrite,
  input  logic             dec_memwrite,
  input  logic [1:0]       dec_wdsel,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [2:0] next_state;
  logic [1:0] next_fault;
  logic       is_load;
  logic       is_store;
  logic       wait_clr;
  logic       wait_en;
  logic       wait_tc;

  assign is_load  = (dec_wdsel == WDSEL_LOAD);
  assign is_store = dec_memwrite;
  assign halted   = (state == ST_HALT);

  // Timer only runs while a request is outstanding; any other state keeps it cleared.
  always_comb begin
    wait_clr = 1'b1;
    wait_en  = 1'b0;
    case (state)
      ST_FETCH: begin
        wait_clr = !run || imem_ready;
        wait_en  = run && !imem_ready;
      end
      ST_MEM: begin
        wait_clr = dmem_ready;
        wait_en  = !dmem_ready;
      end
      default: ;
    endcase
  end

  mc_wait_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (wait_clr),
    .en   (wait_en),
    .tc   (wait_tc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_FETCH;
      fault <= FLT_NONE;
    end else begin
      state <= next_state;
      fault <= next_fault;
    end
  end

  always_comb begin
    next_state = state;
    next_fault = fault;
    case (state)
      ST_FETCH: begin
        if (run) begin
          if (imem_ready) begin
            next_state = ST_DECODE;
          end else if (wait_tc) begin
            next_state = ST_HALT;
            next_fault = FLT_IMEM_TO;
          end
        end
      end
      ST_DECODE: begin
        if (!op_legal(Op)) begin
          next_state = ST_HALT;
          next_fault = FLT_ILLEGAL;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store) next_state = ST_MEM;
        else if (dec_regwrite)   next_state = ST_WB;
        else                     next_state = ST_FETCH;
      end
      ST_MEM: begin
        if (dmem_ready) begin
          next_state = is_store ? ST_FETCH : ST_WB;
        end else if (wait_tc) begin
          next_state = ST_HALT;
          next_fault = FLT_DMEM_TO;
        end
      end
      ST_WB:   next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_HALT;
    endcase
  end

  // Strobes are held low while rstn is asserted so an aborted access never commits.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    if (rstn) begin
      case (state)
        ST_FETCH: begin
          imem_req = run;
          ir_we    = run && imem_ready;
        end
        ST_EXEC: pc_we = !(is_load || is_store) && !dec_regwrite;
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          mdr_we   = dmem_ready && !is_store;
          pc_we    = dmem_ready && is_store;
        end
        ST_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!halted) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (pc_we)   instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It gates the static decoder outputs (RegWrite, MemWrite, WDSel) into single-cycle write strobes, and handshakes with the instruction and data memories. It sits between the combinational decoder and the PC, IR, MDR and register-file write enables. It also detects illegal opcodes and memory timeouts, and keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt (wrap modulo 2^CNT_W)
TO_W, 8, width of the memory-wait timer
TIMEOUT, 200, max cycles waiting for imem_ready/dmem_ready before fault (1..2^TO_W-1)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  synchronous active-low reset
run  in  1  enable; sampled only in FETCH; low holds in FETCH with imem_req=0
Op  in  7  opcode field of IR
dec_regwrite  in  1  decoder RegWrite
dec_memwrite  in  1  decoder MemWrite (store)
dec_wdsel  in  2  decoder WDSel; 2'b11 = load
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
dmem_req  out  1  data access request
dmem_we  out  1  data write qualifier (valid only with dmem_req)
dmem_ready  in  1  data access complete this cycle
ir_we  out  1  IR load strobe
mdr_we  out  1  MDR load strobe
rf_we  out  1  register-file write strobe
pc_we  out  1  PC update strobe (next PC from NPC logic)
state  out  3  current state encoding
halted  out  1  sticky halt flag
fault  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
cycle_cnt  out  CNT_W  cycles since reset, frozen while halted
instret_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset (rstn=0 at a clk edge): state=FETCH, halted=0, fault=00, both counters 0, wait timer 0. All strobes are combinational from state and are therefore 0 except as stated for FETCH. Reset mid-access abandons the access; no strobe is issued.
- Legal Op: 0110011, 0000011, 0010011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Op=0000000 is NOP. Every other Op is illegal.
- FETCH: imem_req=run.
  - run & imem_ready: ir_we=1 the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Illegal Op: go to HALT with fault=01.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - Load (dec_wdsel=11) or store (dec_memwrite): go to MEM.
  - Else if dec_regwrite: go to WB.
  - Else (branch, NOP): pc_we=1, instret++, go to FETCH.
- MEM: dmem_req=1, dmem_we=dec_memwrite.
  - On dmem_ready with a store: pc_we=1, instret++, go to FETCH.
  - On dmem_ready with a load: mdr_we=1, go to WB.
- WB (1 cycle): rf_we=1, pc_we=1, instret++, go to FETCH.
- HALT: all strobes and reqs 0, halted=1. Stays in HALT until reset; run is ignored.
- Wait timer:
  - Clears on entry to FETCH/MEM and on each ready.
  - Increments each cycle a req is high without ready.
  - When it reaches TIMEOUT-1 and ready is still low: go to HALT, fault=10 (FETCH) or 11 (MEM).
  - Ready in that same cycle wins; no fault.
  - With run=0 in FETCH the timer holds at 0.
- Strobe rules: at most one of ir_we, mdr_we, rf_we asserted per cycle. pc_we asserts exactly once per retired instruction.
- Latency with zero-wait memory:
  - ALU/jal/jalr/lui/auipc: 4 cycles
  - branch/NOP: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
- Counters:
  - cycle_cnt increments every cycle while halted=0, and wraps.
  - instret_cnt increments on each pc_we, and wraps.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.

Decomposition:
- Shared package holds:
  - state encoding constants
  - fault code constants
  - RV32I opcode constants (reused by the decoder)
- One sub-module: mc_wait_timer. It is a TO_W counter with clear, enable and a terminal-count output, shared by the FETCH and MEM waits.

Test Plan:
- Reset with run=1, imem_ready=1, Op=0110011, dec_regwrite=1: states 0,1,2,4,0. ir_we at cycle 0, rf_we and pc_we at cycle 3, instret_cnt=1 after 4 cycles.
- Load (Op=0000011, wdsel=11) with dmem_ready delayed 3 cycles: MEM held 4 cycles, mdr_we then rf_we, 8 cycles total, dmem_we=0 throughout.
- Store (Op=0100011, dec_memwrite=1), dmem_ready=1: dmem_req & dmem_we for 1 cycle, pc_we in MEM, no rf_we, 4 cycles.
- Op=1111111: HALT after DECODE with fault=01, halted=1. cycle_cnt frozen, all strobes 0 for 100 cycles, and run toggles are ignored.
- TIMEOUT=5, imem_ready stuck 0: HALT with fault=10 after exactly 5 FETCH-wait cycles. Repeat with ready arriving in the 5th cycle: no fault.
- Assert rstn=0 during MEM: next cycle state=FETCH, counters 0, no mdr_we/rf_we/pc_we ever emitted for the aborted instruction.
